// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder reused LSB-first over WIDTH clocks.
// Registered busy/done/sum/cout, asynchronous active-high reset.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic c,
   output logic sum,
   output logic carry
);
   assign sum   = a ^ b ^ c;
   assign carry = (a & b) | (c & (a ^ b));
endmodule

module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             fa_sum, fa_carry;
   logic [WIDTH:0]   res_cat;
   logic             last_bit;

   full_adder u_fa (
      .a     (a_q[0]),
      .b     (b_q[0]),
      .c     (carry_q),
      .sum   (fa_sum),
      .carry (fa_carry)
   );

   // New sum bit enters at the MSB; the result register shifts right.
   assign res_cat  = {fa_sum, res_q};
   assign last_bit = (cnt_q == CW'(WIDTH - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      cout_d  = cout_q;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            res_d   = res_cat[WIDTH:1];
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            carry_d = fa_carry;
            cnt_d   = cnt_q + CW'(1);
            if (last_bit) begin
               sum_d   = res_cat[WIDTH:1];
               cout_d  = fa_carry;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d == RUN);
      done_d = (state_d == DONE);
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 1..32.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: start  input  1  request to add; sampled only in IDLE.
REQ-005 Port: a  input  WIDTH  operand A; captured when start is accepted.
REQ-006 Port: b  input  WIDTH  operand B; captured when start is accepted.
REQ-007 Port: cin  input  1  carry-in; captured when start is accepted.
REQ-008 Port: busy  output  1  high while in RUN.
REQ-009 Port: done  output  1  one-cycle pulse; result valid.
REQ-010 Port: sum  output  WIDTH  registered result of a+b+cin, modulo 2^WIDTH.
REQ-011 Port: cout  output  1  registered carry-out of the addition.

Function
REQ-012 The block SHALL compute sum/cout bit-serially, LSB first, one bit per clock.
REQ-013 It SHALL use exactly one instance of the existing full_adder module (ports a, b, c, sum, carry) as its only adder datapath.
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE; the encoding is free.
REQ-015 IDLE: when start=1 at an edge, the block SHALL load a and b into shift registers, load cin into the carry flop, clear the bit counter and go to RUN; otherwise it stays in IDLE.
REQ-016 RUN, per edge: the full_adder inputs SHALL be A shift LSB, B shift LSB and the carry flop.
REQ-017 RUN, per edge: the full_adder sum bit SHALL enter the result shift register at its MSB, which shifts right.
REQ-018 RUN, per edge: the carry flop SHALL take the full_adder carry, both operand shift registers SHALL shift right and the counter SHALL increment.
REQ-019 On the edge that processes bit WIDTH-1, the block SHALL copy the completed result into sum and the final carry into cout, and go to DONE.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-021 Latency: if start is accepted at edge k, done SHALL be high from edge k+WIDTH to edge k+WIDTH+1; the throughput limit is one addition per WIDTH+2 cycles.
REQ-022 busy SHALL be 1 exactly in RUN and done SHALL be 1 exactly in DONE; both are registered and glitch-free.
REQ-023 start SHALL be ignored in RUN and DONE, with no queuing; changes on a, b and cin after acceptance SHALL have no effect.
REQ-024 sum and cout SHALL hold the previous result through IDLE and RUN and change only on the completion edge.
REQ-025 For WIDTH=1 the block SHALL spend one cycle in RUN.
REQ-026 The counter SHALL be sized $clog2(WIDTH+1) bits and SHALL never wrap during an operation.

Reset
REQ-027 While reset=1 the block SHALL force, without waiting for a clock edge: state=IDLE, busy=0, done=0, sum=0, cout=0, and clear the counter, carry flop and shift registers.
REQ-028 Reset asserted mid-RUN SHALL abandon the operation, SHALL produce no done pulse and SHALL leave sum unchanged from 0.
REQ-029 After reset deasserts, the first start SHALL be accepted on the first rising edge at which start=1.

Verification (WIDTH=8; start pulsed for one cycle at edge k unless noted)
REQ-030 a=0x5A, b=0x3C, cin=0 -> done at edge k+8, sum=0x96, cout=0, busy high for 8 cycles.
REQ-031 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-032 start re-pulsed at k+3 with a=0x01, b=0x01 -> ignored; the result is still that of the first operation, with exactly one done pulse.
REQ-033 reset asserted at k+4 -> busy, done, sum and cout are 0 immediately with no done pulse; a new start of 0x10+0x20 -> sum=0x30.
REQ-034 start held high continuously with fixed operands -> done pulses every 10 cycles, sum stable between pulses.
REQ-035 Exhaustive sweep at WIDTH=4 of all a, b and cin -> {cout,sum} equals a+b+cin in every case.
